config_reg_bank: RTL and testbench
==================================

Name: config_reg_bank

Overview:
- Parametrised successor to the single configuration register: a bank of NUM_REGS payload-wide configuration registers on the packet interconnect.
- Register addresses are BASE_ADDR..BASE_ADDR+NUM_REGS-1.
- Messages addressed to the bank perform a write or a read-back and return a response; all other messages forward unchanged.
- The output stage is val/rdy with one-entry buffering; register contents drive the fabric continuously.

Parameters:
ADDR_SIZE, 4, width of message address field
PAYLOAD_SIZE, 8, width of payload field and of each config register
NUM_REGS, 4, number of registers in bank; 1 <= NUM_REGS, and BASE_ADDR+NUM_REGS <= 2**ADDR_SIZE
BASE_ADDR, 0, address of register 0

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
recv_val  input  1  inbound message valid
recv_rdy  output  1  bank can accept inbound message
recv_msg  input  ADDR_SIZE+PAYLOAD_SIZE+1  inbound message {addr, wr, payload}
send_val  output  1  outbound message valid
send_rdy  input  1  downstream accepts outbound message
send_msg  output  ADDR_SIZE+PAYLOAD_SIZE+1  outbound message {addr, wr, payload}
cfg_out  output  NUM_REGS*PAYLOAD_SIZE  register contents; reg i at bits [i*PAYLOAD_SIZE +: PAYLOAD_SIZE]
cfg_wr_pulse  output  NUM_REGS  one-cycle pulse, bit i set in the cycle after reg i is written

Behaviour:
- Message fields:
  - addr = msg[MSG_W-1 -: ADDR_SIZE]
  - wr = msg[PAYLOAD_SIZE]
  - payload = msg[PAYLOAD_SIZE-1:0]
  - MSG_W = ADDR_SIZE+PAYLOAD_SIZE+1
- Reset (async, immediate on assertion, regardless of clk):
  - all registers = 0, so cfg_out = 0
  - send_val = 0, send_msg = 0, cfg_wr_pulse = 0
  - any buffered message is discarded
- Handshake:
  - Transfer on recv when recv_val && recv_rdy.
  - recv_rdy = !send_val || send_rdy (combinational; registered output, no bypass).
  - Transfer on send when send_val && send_rdy.
- Output buffer: one entry (send_msg, send_val).
  - On a recv transfer, the buffer loads at the next edge; send_val = 1 from the cycle after acceptance (latency 1).
  - Send transfer without a recv transfer: send_val clears at the edge.
  - Simultaneous send and recv transfer: the buffer is replaced by the new message; throughput is 1 message/cycle.
  - While send_val && !send_rdy: send_msg and send_val hold stable, recv_rdy = 0.
- Decode (only on recv transfer): hit = (addr >= BASE_ADDR) && (addr < BASE_ADDR+NUM_REGS); idx = addr - BASE_ADDR.
  - hit, wr=1:
    - reg[idx] <= payload at the same edge the buffer loads.
    - Response = recv_msg unchanged (echo).
    - cfg_wr_pulse[idx] = 1 for exactly one cycle after that edge.
  - hit, wr=0: reg unchanged; response = {addr, 1'b0, reg[idx] value before the edge}.
  - miss: no register effect; response = recv_msg unchanged (forward).
- Back-pressure never loses or duplicates a message. A stalled cycle performs no register write and no pulse.
- cfg_out updates only on a hit-write edge. cfg_out is unaffected by send_rdy once the write is accepted.
- Reset asserted mid-stall: the buffered message is dropped and registers are cleared. After deassertion, send_val = 0 and recv_rdy = 1.
- Address arithmetic is unsigned in ADDR_SIZE bits. The range compare must not wrap when BASE_ADDR+NUM_REGS = 2**ADDR_SIZE.

Test Plan:
- Reset then idle (recv_val=0, send_rdy=1) -> send_val=0, recv_rdy=1, cfg_out=0, cfg_wr_pulse=0.
- Write: recv 13'b0001_1_10101010 (addr 1, BASE_ADDR 0) -> next cycle send_msg=13'b0001_1_10101010, send_val=1, cfg_out[15:8]=8'hAA, cfg_wr_pulse=4'b0010 for one cycle.
- Read-back: write 8'h55 to addr 3, then recv {4'd3,1'b0,8'h00} -> send_msg={4'd3,1'b0,8'h55}; registers unchanged.
- Miss: recv 13'b0101_1_01010101 (addr 5) -> forwarded unchanged; cfg_out unchanged; no pulse.
- Back-pressure: send_rdy=0 after a write to addr 0 -> send_msg held, recv_rdy=0, second offered message not accepted. Raise send_rdy -> both messages emerge in order, one per cycle; exactly one pulse per write.
- Async reset mid-stall with cfg_out=8'hAA in reg 1 -> immediately send_val=0, cfg_out=0. First message after release is accepted with latency 1.

Source files
------------

// File: rtl/config_reg_bank_if.sv
// config_reg_bank_if: val/rdy message ports of the config register bank.
interface config_reg_bank_if #(parameter int MSG_W = 13);
    logic             recv_val;
    logic             recv_rdy;
    logic [MSG_W-1:0] recv_msg;
    logic             send_val;
    logic             send_rdy;
    logic [MSG_W-1:0] send_msg;
    modport slave (input recv_val, recv_msg, send_rdy, output recv_rdy, send_val, send_msg);
    modport master (output recv_val, recv_msg, send_rdy, input recv_rdy, send_val, send_msg);
endinterface

// File: rtl/config_reg_bank.sv
// config_reg_bank: bank of NUM_REGS config registers on the packet interconnect;
// hits write or read back a register, misses forward unchanged through a one-entry output buffer.
module config_reg_bank #(
    parameter int ADDR_SIZE    = 4,
    parameter int PAYLOAD_SIZE = 8,
    parameter int NUM_REGS     = 4,
    parameter int BASE_ADDR    = 0
) (
    input  logic                             clk,
    input  logic                             reset,
    config_reg_bank_if.slave                 bus,
    output logic [NUM_REGS*PAYLOAD_SIZE-1:0] cfg_out,
    output logic [NUM_REGS-1:0]              cfg_wr_pulse
);
    localparam int MSG_W = ADDR_SIZE + PAYLOAD_SIZE + 1;
    localparam int IDX_W = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    logic [NUM_REGS-1:0][PAYLOAD_SIZE-1:0] regs;
    logic [ADDR_SIZE-1:0] addr;
    logic [ADDR_SIZE:0]   addr_ext;
    logic [IDX_W-1:0]     idx;
    logic                 wr, hit, xfer;
    logic [MSG_W-1:0]     resp;

    assign addr     = bus.recv_msg[MSG_W-1 -: ADDR_SIZE];
    assign wr       = bus.recv_msg[PAYLOAD_SIZE];
    // One extra bit keeps the upper bound from wrapping when the bank ends at the top of the address space
    assign addr_ext = {1'b0, addr};
    assign hit      = addr_ext >= (ADDR_SIZE+1)'(BASE_ADDR) && addr_ext < (ADDR_SIZE+1)'(BASE_ADDR + NUM_REGS);
    assign idx      = IDX_W'(addr - ADDR_SIZE'(BASE_ADDR));
    assign resp     = (hit && !wr) ? {addr, 1'b0, regs[idx]} : bus.recv_msg;
    assign bus.recv_rdy = !bus.send_val || bus.send_rdy;
    assign xfer     = bus.recv_val && bus.recv_rdy;
    assign cfg_out  = regs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs         <= '0;
            bus.send_val <= 1'b0;
            bus.send_msg <= '0;
            cfg_wr_pulse <= '0;
        end else begin
            cfg_wr_pulse <= '0;
            if (xfer) begin
                bus.send_val <= 1'b1;
                bus.send_msg <= resp;
                if (hit && wr) begin
                    regs[idx]         <= bus.recv_msg[PAYLOAD_SIZE-1:0];
                    cfg_wr_pulse[idx] <= 1'b1;
                end
            end else if (bus.send_rdy) begin
                bus.send_val <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_config_reg_bank.sv
// tb_config_reg_bank: table-driven vectors plus hand sequences, responses checked via a scoreboard queue.
module tb_config_reg_bank;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cfg_out;
    logic [3:0]  cfg_wr_pulse;
    logic [12:0] exp_resp;
    logic [12:0] q[$];
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [12:0] msg;
        logic [12:0] resp;
        logic [31:0] cfg;
        logic [3:0]  pulse;
    } vec_t;
    vec_t tbl[10];

    config_reg_bank_if #(.MSG_W(13)) bus ();

    config_reg_bank #(.ADDR_SIZE(4), .PAYLOAD_SIZE(8), .NUM_REGS(4), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave), .cfg_out(cfg_out), .cfg_wr_pulse(cfg_wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.send_val && bus.send_rdy) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_send got=%h want=none at %0t", bus.send_msg, $time);
                end else begin
                    chk("send_msg", 32'(bus.send_msg), 32'(q.pop_front()));
                end
            end
            if (bus.recv_val && bus.recv_rdy) q.push_back(exp_resp);
        end
    end

    initial begin
        tbl[0] = '{{4'd1, 1'b1, 8'hAA}, {4'd1, 1'b1, 8'hAA}, 32'h0000AA00, 4'b0010};
        tbl[1] = '{{4'd3, 1'b1, 8'h55}, {4'd3, 1'b1, 8'h55}, 32'h5500AA00, 4'b1000};
        tbl[2] = '{{4'd3, 1'b0, 8'h00}, {4'd3, 1'b0, 8'h55}, 32'h5500AA00, 4'b0000};
        tbl[3] = '{{4'd5, 1'b1, 8'h55}, {4'd5, 1'b1, 8'h55}, 32'h5500AA00, 4'b0000};
        tbl[4] = '{{4'd1, 1'b0, 8'hFF}, {4'd1, 1'b0, 8'hAA}, 32'h5500AA00, 4'b0000};
        tbl[5] = '{{4'd0, 1'b1, 8'h11}, {4'd0, 1'b1, 8'h11}, 32'h5500AA11, 4'b0001};
        tbl[6] = '{{4'd4, 1'b0, 8'h12}, {4'd4, 1'b0, 8'h12}, 32'h5500AA11, 4'b0000};
        tbl[7] = '{{4'd15, 1'b1, 8'hFF}, {4'd15, 1'b1, 8'hFF}, 32'h5500AA11, 4'b0000};
        tbl[8] = '{{4'd2, 1'b1, 8'h7E}, {4'd2, 1'b1, 8'h7E}, 32'h557EAA11, 4'b0100};
        tbl[9] = '{{4'd2, 1'b0, 8'h00}, {4'd2, 1'b0, 8'h7E}, 32'h557EAA11, 4'b0000};

        reset = 1'b1;
        bus.recv_val = 1'b0;
        bus.recv_msg = '0;
        bus.send_rdy = 1'b1;
        exp_resp = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_send_val", 32'(bus.send_val), 0);
        chk("rst_recv_rdy", 32'(bus.recv_rdy), 1);
        chk("rst_cfg_out", cfg_out, 0);
        chk("rst_pulse", 32'(cfg_wr_pulse), 0);
        @(posedge clk);
        #1 chk("idle_send_val", 32'(bus.send_val), 0);

        for (int i = 0; i < 10; i++) begin
            bus.recv_val = 1'b1;
            bus.recv_msg = tbl[i].msg;
            exp_resp = tbl[i].resp;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_cfg", i), cfg_out, tbl[i].cfg);
            chk($sformatf("vec%0d_pulse", i), 32'(cfg_wr_pulse), 32'(tbl[i].pulse));
            chk($sformatf("vec%0d_send_val", i), 32'(bus.send_val), 1);
        end
        bus.recv_val = 1'b0;
        @(posedge clk);
        #1 chk("after_tbl_pulse", 32'(cfg_wr_pulse), 0);

        // back-pressure: write reg 0, stall, offer a read of reg 1
        bus.recv_val = 1'b1;
        bus.recv_msg = {4'd0, 1'b1, 8'h33};
        exp_resp = {4'd0, 1'b1, 8'h33};
        @(posedge clk);
        #1;
        chk("bp_pulse", 32'(cfg_wr_pulse), 32'b0001);
        chk("bp_cfg", cfg_out, 32'h557EAA33);
        bus.send_rdy = 1'b0;
        bus.recv_msg = {4'd1, 1'b0, 8'h00};
        exp_resp = {4'd1, 1'b0, 8'hAA};
        #3 chk("bp_recv_rdy", 32'(bus.recv_rdy), 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_msg", 32'(bus.send_msg), 32'({4'd0, 1'b1, 8'h33}));
            chk("bp_hold_val", 32'(bus.send_val), 1);
            chk("bp_stall_pulse", 32'(cfg_wr_pulse), 0);
        end
        bus.send_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.recv_val = 1'b0;
        chk("bp_second_msg", 32'(bus.send_msg), 32'({4'd1, 1'b0, 8'hAA}));
        chk("bp_second_pulse", 32'(cfg_wr_pulse), 0);
        chk("bp_second_cfg", cfg_out, 32'h557EAA33);
        @(posedge clk);
        #1 chk("bp_drained", 32'(bus.send_val), 0);

        // async reset while a write response is stalled
        bus.recv_val = 1'b1;
        bus.recv_msg = {4'd1, 1'b1, 8'hAA};
        exp_resp = {4'd1, 1'b1, 8'hAA};
        @(posedge clk);
        #1;
        bus.recv_val = 1'b0;
        bus.send_rdy = 1'b0;
        chk("ar_pre_val", 32'(bus.send_val), 1);
        chk("ar_pre_cfg", 32'(cfg_out[15:8]), 32'hAA);
        #2 reset = 1'b1;
        #1;
        chk("ar_send_val", 32'(bus.send_val), 0);
        chk("ar_cfg_out", cfg_out, 0);
        q.delete();
        @(posedge clk);
        #1 reset = 1'b0;
        chk("ar_post_val", 32'(bus.send_val), 0);
        chk("ar_post_rdy", 32'(bus.recv_rdy), 1);
        bus.send_rdy = 1'b1;
        bus.recv_val = 1'b1;
        bus.recv_msg = {4'd5, 1'b1, 8'h3C};
        exp_resp = {4'd5, 1'b1, 8'h3C};
        @(posedge clk);
        #1;
        bus.recv_val = 1'b0;
        chk("ar_lat1_val", 32'(bus.send_val), 1);
        chk("ar_lat1_msg", 32'(bus.send_msg), 32'({4'd5, 1'b1, 8'h3C}));
        @(posedge clk);
        #1;
        chk("end_send_val", 32'(bus.send_val), 0);
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
